// File: rtl/two_bit_comparator.sv
// two_bit_comparator
//   Registered 2-bit unsigned magnitude comparator. A = {a1,a0} is compared
//   against B = {b1,b0} using 1-bit comparator cells and an MSB-priority
//   combine stage. The three flags are mutually exclusive once out of reset.
//
// Ports
//   clk    : system clock, rising-edge active
//   rst_n  : asynchronous, active-low reset (clears all flags)
//   a0, a1 : operand A, LSB and MSB
//   b0, b1 : operand B, LSB and MSB
//   out    : A >  B, registered
//   out1   : A == B, registered
//   out2   : A <  B, registered
//
// Configuration
//   TWO_BIT_COMPARATOR_INREG_EN : when defined, the operands are first
//   captured in an input register stage, which is reset to 0. Latency then
//   becomes 2 clocks. When undefined, latency is 1 clock.

// 1-bit comparator cell: reports whether a is greater, less or equal to b.
module two_bit_comparator_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  logic a_n;
  logic b_n;
  logic ne;

  not u_not_a (a_n, a);
  not u_not_b (b_n, b);
  and u_and_gt (gt, a, b_n);
  and u_and_lt (lt, a_n, b);
  or  u_or_ne  (ne, gt, lt);
  not u_not_eq (eq, ne);

endmodule

module two_bit_comparator (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic b0,
  input  logic a1,
  input  logic b1,
  output logic out,
  output logic out1,
  output logic out2
);

  logic a0_c;
  logic b0_c;
  logic a1_c;
  logic b1_c;

`ifdef TWO_BIT_COMPARATOR_INREG_EN
  // Optional input stage. Cleared operands compare equal, so the flags
  // report equal on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_c <= 1'b0;
      b0_c <= 1'b0;
      a1_c <= 1'b0;
      b1_c <= 1'b0;
    end else begin
      a0_c <= a0;
      b0_c <= b0;
      a1_c <= a1;
      b1_c <= b1;
    end
  end
`else
  assign a0_c = a0;
  assign b0_c = b0;
  assign a1_c = a1;
  assign b1_c = b1;
`endif

  logic gt0;
  logic lt0;
  logic eq0;
  logic gt1;
  logic lt1;
  logic eq1;

  two_bit_comparator_cell u_cell0 (
    .a  (a0_c),
    .b  (b0_c),
    .gt (gt0),
    .lt (lt0),
    .eq (eq0)
  );

  two_bit_comparator_cell u_cell1 (
    .a  (a1_c),
    .b  (b1_c),
    .gt (gt1),
    .lt (lt1),
    .eq (eq1)
  );

  // The MSB cell decides unless its bits are equal; only then does the
  // LSB cell contribute.
  logic gt_lsb;
  logic lt_lsb;
  logic gt_all;
  logic lt_all;
  logic eq_all;

  and u_and_gt_lsb (gt_lsb, eq1, gt0);
  and u_and_lt_lsb (lt_lsb, eq1, lt0);
  or  u_or_gt_all  (gt_all, gt1, gt_lsb);
  or  u_or_lt_all  (lt_all, lt1, lt_lsb);
  and u_and_eq_all (eq_all, eq1, eq0);

  // Output flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= 1'b0;
      out1 <= 1'b0;
      out2 <= 1'b0;
    end else begin
      out  <= gt_all;
      out1 <= eq_all;
      out2 <= lt_all;
    end
  end

endmodule

// File: tb/tb_two_bit_comparator.sv
// tb_two_bit_comparator
//   Directed-vector bench for two_bit_comparator. Flags are packed as
//   {out, out1, out2}: 3'b100 = greater, 3'b010 = equal, 3'b001 = less.
//   Honours TWO_BIT_COMPARATOR_INREG_EN for the expected latency.

module tb_two_bit_comparator;

`ifdef TWO_BIT_COMPARATOR_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] F_GT  = 3'b100;
  localparam logic [2:0] F_EQ  = 3'b010;
  localparam logic [2:0] F_LT  = 3'b001;
  localparam logic [2:0] F_RST = 3'b000;

  logic clk;
  logic rst_n;
  logic a0;
  logic b0;
  logic a1;
  logic b1;
  logic out;
  logic out1;
  logic out2;

  int errors;
  int checks;

  two_bit_comparator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .out   (out),
    .out1  (out1),
    .out2  (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken clock or stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [2:0] got,
                              input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive operands away from the active edge, then let them propagate.
  task automatic apply_stimulus(input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    a1 = a[1];
    a0 = a[0];
    b1 = b[1];
    b0 = b[0];
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model(input int a, input int b);
    if (a > b)      return F_GT;
    else if (a < b) return F_LT;
    else            return F_EQ;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a1 = 1'b0; a0 = 1'b1;
    b1 = 1'b0; b0 = 1'b0;

    // Reset held while clock runs with A = 1, B = 0.
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", {out, out1, out2}, F_RST);

    // Release reset; first edge loads A > B (or the cleared input stage).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_release_1", {out, out1, out2}, (LAT == 1) ? F_GT : F_EQ);
    if (LAT == 2) begin
      @(posedge clk);
      #1;
      check_output("reset_release_2", {out, out1, out2}, F_GT);
    end

    // Directed vectors with hand-computed results.
    apply_stimulus(2'b00, 2'b00);
    check_output("a0_b0_eq", {out, out1, out2}, F_EQ);
    apply_stimulus(2'b00, 2'b10);
    check_output("a0_b2_lt", {out, out1, out2}, F_LT);
    apply_stimulus(2'b10, 2'b00);
    check_output("a2_b0_gt", {out, out1, out2}, F_GT);
    apply_stimulus(2'b01, 2'b01);
    check_output("a1_b1_eq", {out, out1, out2}, F_EQ);
    apply_stimulus(2'b01, 2'b10);
    check_output("a1_b2_msb_lt", {out, out1, out2}, F_LT);
    apply_stimulus(2'b10, 2'b01);
    check_output("a2_b1_msb_gt", {out, out1, out2}, F_GT);
    apply_stimulus(2'b11, 2'b11);
    check_output("a3_b3_eq", {out, out1, out2}, F_EQ);
    apply_stimulus(2'b11, 2'b00);
    check_output("a3_b0_gt", {out, out1, out2}, F_GT);
    apply_stimulus(2'b00, 2'b11);
    check_output("a0_b3_lt", {out, out1, out2}, F_LT);
    apply_stimulus(2'b11, 2'b10);
    check_output("a3_b2_lsb_gt", {out, out1, out2}, F_GT);
    apply_stimulus(2'b10, 2'b11);
    check_output("a2_b3_lsb_lt", {out, out1, out2}, F_LT);

    // Full sweep with a mid-sweep asynchronous reset pulse.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] av;
      logic [1:0] bv;
      logic [2:0] flags;
      av = 2'(i >> 2);
      bv = 2'(i & 3);
      apply_stimulus(av, bv);
      flags = {out, out1, out2};
      check_output($sformatf("sweep_a%0d_b%0d", av, bv), flags, model(int'(av), int'(bv)));
      check_output($sformatf("onehot_a%0d_b%0d", av, bv),
                   {2'b00, ($countones(flags) == 1)}, 3'b001);
      if (i == 8) begin
        // Between edges: reset must clear the flags without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midsweep_reset", {out, out1, out2}, F_RST);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check_output("midsweep_resume", {out, out1, out2},
                     model(int'(av), int'(bv)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
